// File: rtl/risc_pkg.sv
// risc_pkg
// Shared constants for the RISC memory arbiter slice: default address and
// data widths for the 32x8 RAM, the arbiter FSM state encoding and the
// owner encoding used on the owner output and the last_served register.
package risc_pkg;

    localparam int AW = 5;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// risc_mem_arbiter_if
// Bundles the three buses around the arbiter.
//   CPU side  : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_ack out
//   Host side : host_req/host_we/host_addr/host_wdata in, host_rdata/host_ack out
//   RAM side  : mem_addr/mem_wdata/mem_rd/mem_wr out, mem_rdata in
//   Status    : owner out (0 = CPU, 1 = host)
// The slave modport is the arbiter's view; master is the view of whatever
// drives the requesters and models the RAM.
interface risc_mem_arbiter_if #(
    parameter int AW = risc_pkg::AW,
    parameter int DW = risc_pkg::DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata,
        input  owner
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way picker.
//   req_a, req_b : requests (a = CPU, b = host)
//   last         : 1 when b was served last, 0 when a was served last
//   prio_b       : 1 makes b win every tie
//   gnt_a, gnt_b : one-hot (or zero) grant
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic prio_b,
    output logic gnt_a,
    output logic gnt_b
);

    // On a tie b wins if it has fixed priority or if a was served last.
    assign gnt_b = req_b & (~req_a | prio_b | ~last);
    assign gnt_a = req_a & ~gnt_b;

endmodule

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter
// Shares the single 32x8 RISC RAM between the CPU and the host loader port.
// Each transaction: grant in IDLE, WAIT_CYC+1 cycles of ACCESS with the
// strobe held, then one RESP cycle carrying the owner's ack.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : CPU, host and RAM buses plus owner (slave modport)
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int AW        = risc_pkg::AW,
    parameter int DW        = risc_pkg::DW,
    parameter int WAIT_CYC  = 1,
    parameter int HOST_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    risc_mem_arbiter_if.slave   bus
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);
    localparam logic       PRIO_B    = 1'(HOST_PRIO);

    arb_state_t    state,      state_n;
    logic [2:0]    wait_cnt,   wait_cnt_n;
    logic          op_we,      op_we_n;
    logic [AW-1:0] addr_q,     addr_n;
    logic [DW-1:0] wdata_q,    wdata_n;
    logic          owner_q,    owner_n;
    logic          last_q,     last_n;
    logic [DW-1:0] cpu_rd_q,   cpu_rd_n;
    logic [DW-1:0] host_rd_q,  host_rd_n;
    logic          gnt_cpu,    gnt_host;

    rr_arb2 u_pick (
        .req_a  (bus.cpu_req),
        .req_b  (bus.host_req),
        .last   (last_q),
        .prio_b (PRIO_B),
        .gnt_a  (gnt_cpu),
        .gnt_b  (gnt_host)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_we     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            owner_q   <= OWN_HOST;
            last_q    <= OWN_HOST;
            cpu_rd_q  <= '0;
            host_rd_q <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            op_we     <= op_we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            cpu_rd_q  <= cpu_rd_n;
            host_rd_q <= host_rd_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        op_we_n    = op_we;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        owner_n    = owner_q;
        last_n     = last_q;
        cpu_rd_n   = cpu_rd_q;
        host_rd_n  = host_rd_q;
        case (state)
            IDLE: begin
                if (gnt_host) begin
                    owner_n    = OWN_HOST;
                    addr_n     = bus.host_addr;
                    wdata_n    = bus.host_wdata;
                    op_we_n    = bus.host_we;
                    wait_cnt_n = WAIT_INIT;
                    state_n    = ACCESS;
                end else if (gnt_cpu) begin
                    owner_n    = OWN_CPU;
                    addr_n     = bus.cpu_addr;
                    wdata_n    = bus.cpu_wdata;
                    op_we_n    = bus.cpu_we;
                    wait_cnt_n = WAIT_INIT;
                    state_n    = ACCESS;
                end
            end
            ACCESS: begin
                // RAM data is only guaranteed valid in the final ACCESS cycle.
                if (wait_cnt == 3'd0) begin
                    if (!op_we) begin
                        if (owner_q == OWN_HOST) host_rd_n = bus.mem_rdata;
                        else                     cpu_rd_n  = bus.mem_rdata;
                    end
                    state_n = RESP;
                end else begin
                    wait_cnt_n = wait_cnt - 3'd1;
                end
            end
            RESP: begin
                last_n  = owner_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes and acks decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    assign bus.mem_rd     = (state == ACCESS) & ~op_we;
    assign bus.mem_wr     = (state == ACCESS) &  op_we;
    assign bus.cpu_ack    = (state == RESP) & (owner_q == OWN_CPU);
    assign bus.host_ack   = (state == RESP) & (owner_q == OWN_HOST);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rdata  = cpu_rd_q;
    assign bus.host_rdata = host_rd_q;
    assign bus.owner      = owner_q;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// tb_risc_mem_arbiter
// Directed bench with three arbiter instances sharing clk/rst:
//   dut0 : WAIT_CYC=1, HOST_PRIO=0
//   dut1 : WAIT_CYC=1, HOST_PRIO=1
//   dut2 : WAIT_CYC=3, HOST_PRIO=0
// Each instance has its own 32x8 RAM model. Inputs change and outputs are
// sampled on the falling edge; "cycle k" is the k-th falling edge after the
// one where the request was raised.
module tb_risc_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    risc_mem_arbiter_if #(.AW(5), .DW(8)) if0 ();
    risc_mem_arbiter_if #(.AW(5), .DW(8)) if1 ();
    risc_mem_arbiter_if #(.AW(5), .DW(8)) if2 ();

    risc_mem_arbiter #(.AW(5), .DW(8), .WAIT_CYC(1), .HOST_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    risc_mem_arbiter #(.AW(5), .DW(8), .WAIT_CYC(1), .HOST_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    risc_mem_arbiter #(.AW(5), .DW(8), .WAIT_CYC(3), .HOST_PRIO(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];

    assign if0.mem_rdata = mem0[if0.mem_addr];
    assign if1.mem_rdata = mem1[if1.mem_addr];
    assign if2.mem_rdata = mem2[if2.mem_addr];

    always @(posedge clk) if (if0.mem_wr) mem0[if0.mem_addr] = if0.mem_wdata;
    always @(posedge clk) if (if1.mem_wr) mem1[if1.mem_addr] = if1.mem_wdata;
    always @(posedge clk) if (if2.mem_wr) mem2[if2.mem_addr] = if2.mem_wdata;

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if ({if0.mem_rd, if0.mem_wr} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b want 00", {if0.mem_rd, if0.mem_wr}); else n_pass++;
        n_total++; if ({if0.cpu_ack, if0.host_ack} !== 2'b00) $display("[TB] FAIL reset_acks: got %b want 00", {if0.cpu_ack, if0.host_ack}); else n_pass++;
        n_total++; if ({if0.mem_addr, if0.mem_wdata} !== 13'h0) $display("[TB] FAIL reset_mem_bus: got %h want 0", {if0.mem_addr, if0.mem_wdata}); else n_pass++;
        n_total++; if ({if0.cpu_rdata, if0.host_rdata} !== 16'h0) $display("[TB] FAIL reset_rdata: got %h want 0", {if0.cpu_rdata, if0.host_rdata}); else n_pass++;
        n_total++; if (if0.owner !== 1'b1) $display("[TB] FAIL reset_owner: got %b want 1", if0.owner); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        if0.cpu_req = 1'b1; if0.cpu_we = 1'b0; if0.cpu_addr = 5'd5;
        @(negedge clk);
        n_total++; if ({if0.mem_rd, if0.mem_wr} !== 2'b10) $display("[TB] FAIL cpu_rd_c1_strobes: got %b want 10", {if0.mem_rd, if0.mem_wr}); else n_pass++;
        n_total++; if (if0.mem_addr !== 5'd5) $display("[TB] FAIL cpu_rd_addr: got %0d want 5", if0.mem_addr); else n_pass++;
        n_total++; if (if0.owner !== 1'b0) $display("[TB] FAIL cpu_rd_owner: got %b want 0", if0.owner); else n_pass++;
        @(negedge clk);
        n_total++; if ({if0.mem_rd, if0.cpu_ack} !== 2'b10) $display("[TB] FAIL cpu_rd_c2: got %b want 10", {if0.mem_rd, if0.cpu_ack}); else n_pass++;
        @(negedge clk);
        n_total++; if ({if0.mem_rd, if0.cpu_ack, if0.host_ack} !== 3'b010) $display("[TB] FAIL cpu_rd_c3_ack: got %b want 010", {if0.mem_rd, if0.cpu_ack, if0.host_ack}); else n_pass++;
        n_total++; if (if0.cpu_rdata !== 8'hA7) $display("[TB] FAIL cpu_rd_data: got %h want a7", if0.cpu_rdata); else n_pass++;
        n_total++; if (if0.host_rdata !== 8'h00) $display("[TB] FAIL cpu_rd_host_rdata: got %h want 00", if0.host_rdata); else n_pass++;
        if0.cpu_req = 1'b0;
        @(negedge clk);
        n_total++; if (if0.cpu_ack !== 1'b0) $display("[TB] FAIL cpu_rd_ack_pulse: got %b want 0", if0.cpu_ack); else n_pass++;
    endtask

    task automatic test_host_write_cpu_read();
        @(negedge clk);
        if0.host_req = 1'b1; if0.host_we = 1'b1; if0.host_addr = 5'd31; if0.host_wdata = 8'h3C;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) begin
                n_total++; if ({if0.mem_wr, if0.mem_rd, if0.mem_addr, if0.mem_wdata} !== {2'b10, 5'd31, 8'h3C})
                    $display("[TB] FAIL hw_access_c%0d: got wr=%b rd=%b a=%0d d=%h want wr=1 rd=0 a=31 d=3c", k, if0.mem_wr, if0.mem_rd, if0.mem_addr, if0.mem_wdata); else n_pass++;
            end
            if (k == 3) begin
                n_total++; if ({if0.host_ack, if0.mem_wr} !== 2'b10) $display("[TB] FAIL hw_ack: got %b want 10", {if0.host_ack, if0.mem_wr}); else n_pass++;
                n_total++; if (if0.host_rdata !== 8'h00) $display("[TB] FAIL hw_rdata_kept: got %h want 00", if0.host_rdata); else n_pass++;
                if0.host_req = 1'b0;
            end
            if (k == 4) begin
                if0.cpu_req = 1'b1; if0.cpu_we = 1'b0; if0.cpu_addr = 5'd31;
            end
            if (k == 7) begin
                n_total++; if ({if0.cpu_ack, if0.cpu_rdata} !== {1'b1, 8'h3C}) $display("[TB] FAIL hw_cpu_readback: got ack=%b d=%h want ack=1 d=3c", if0.cpu_ack, if0.cpu_rdata); else n_pass++;
                if0.cpu_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        pulse_reset();
        if0.cpu_req  = 1'b1; if0.cpu_we  = 1'b0; if0.cpu_addr  = 5'd5;
        if0.host_req = 1'b1; if0.host_we = 1'b0; if0.host_addr = 5'd31;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = {(k == 3 || k == 11), (k == 7 || k == 15)};
            n_total++; if ({if0.cpu_ack, if0.host_ack} !== exp) $display("[TB] FAIL rr_acks_c%0d: got cpu/host=%b want %b", k, {if0.cpu_ack, if0.host_ack}, exp); else n_pass++;
            if (k == 5) begin
                n_total++; if (if0.owner !== 1'b1) $display("[TB] FAIL rr_owner_c5: got %b want 1", if0.owner); else n_pass++;
            end
            if (k == 7) begin
                n_total++; if (if0.host_rdata !== 8'h3C) $display("[TB] FAIL rr_host_rdata: got %h want 3c", if0.host_rdata); else n_pass++;
            end
            if (k == 15) begin
                if0.cpu_req = 1'b0; if0.host_req = 1'b0;
            end
        end
    endtask

    task automatic test_host_prio();
        logic [1:0] exp;
        pulse_reset();
        if1.cpu_req  = 1'b1; if1.cpu_we  = 1'b0; if1.cpu_addr  = 5'd2;
        if1.host_req = 1'b1; if1.host_we = 1'b0; if1.host_addr = 5'd3;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = {(k == 15), (k == 3 || k == 7 || k == 11)};
            n_total++; if ({if1.cpu_ack, if1.host_ack} !== exp) $display("[TB] FAIL prio_acks_c%0d: got cpu/host=%b want %b", k, {if1.cpu_ack, if1.host_ack}, exp); else n_pass++;
            if (k == 13) begin
                n_total++; if (if1.owner !== 1'b0) $display("[TB] FAIL prio_owner_c13: got %b want 0", if1.owner); else n_pass++;
            end
            if (k == 11) if1.host_req = 1'b0;
            if (k == 15) if1.cpu_req  = 1'b0;
        end
    endtask

    task automatic test_req_drop();
        @(negedge clk);
        if2.cpu_req = 1'b1; if2.cpu_we = 1'b0; if2.cpu_addr = 5'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) if2.cpu_req = 1'b0;
            n_total++; if ({if2.mem_rd, if2.cpu_ack} !== {(k >= 1 && k <= 4), (k == 5)})
                $display("[TB] FAIL drop_c%0d: got rd/ack=%b want %b", k, {if2.mem_rd, if2.cpu_ack}, {(k >= 1 && k <= 4), (k == 5)}); else n_pass++;
            if (k == 5) begin
                n_total++; if (if2.cpu_rdata !== 8'h16) $display("[TB] FAIL drop_rdata: got %h want 16", if2.cpu_rdata); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        if0.host_req = 1'b1; if0.host_we = 1'b1; if0.host_addr = 5'd10; if0.host_wdata = 8'h55;
        @(negedge clk);
        n_total++; if (if0.mem_wr !== 1'b1) $display("[TB] FAIL rstmid_wr_before: got %b want 1", if0.mem_wr); else n_pass++;
        #2 rst = 1'b1; if0.host_req = 1'b0;
        #1;
        n_total++; if ({if0.mem_wr, if0.mem_rd} !== 2'b00) $display("[TB] FAIL rstmid_wr_drop: got %b want 00", {if0.mem_wr, if0.mem_rd}); else n_pass++;
        @(negedge clk);
        n_total++; if ({if0.mem_addr, if0.mem_wdata, if0.cpu_rdata, if0.host_rdata} !== 29'h0) $display("[TB] FAIL rstmid_regs: got %h want 0", {if0.mem_addr, if0.mem_wdata, if0.cpu_rdata, if0.host_rdata}); else n_pass++;
        n_total++; if (if0.owner !== 1'b1) $display("[TB] FAIL rstmid_owner: got %b want 1", if0.owner); else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_total++; if (if0.host_ack !== 1'b0) $display("[TB] FAIL rstmid_no_ack_c%0d: got %b want 0", k, if0.host_ack); else n_pass++;
        end
        if0.cpu_req  = 1'b1; if0.cpu_we  = 1'b0; if0.cpu_addr  = 5'd5;
        if0.host_req = 1'b1; if0.host_we = 1'b0; if0.host_addr = 5'd31;
        @(negedge clk);
        n_total++; if (if0.owner !== 1'b0) $display("[TB] FAIL rstmid_first_grant: got %b want 0", if0.owner); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if ({if0.cpu_ack, if0.host_ack} !== 2'b10) $display("[TB] FAIL rstmid_first_ack: got %b want 10", {if0.cpu_ack, if0.host_ack}); else n_pass++;
        if0.cpu_req = 1'b0; if0.host_req = 1'b0;
        @(negedge clk);
    endtask

    // Safety net in case a scenario ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = 8'(i);
            mem2[i] = 8'(i * 3 + 1);
        end
        mem0[5] = 8'hA7;
        if0.cpu_req = 0; if0.cpu_we = 0; if0.cpu_addr = 0; if0.cpu_wdata = 0;
        if0.host_req = 0; if0.host_we = 0; if0.host_addr = 0; if0.host_wdata = 0;
        if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0;
        if1.host_req = 0; if1.host_we = 0; if1.host_addr = 0; if1.host_wdata = 0;
        if2.cpu_req = 0; if2.cpu_we = 0; if2.cpu_addr = 0; if2.cpu_wdata = 0;
        if2.host_req = 0; if2.host_we = 0; if2.host_addr = 0; if2.host_wdata = 0;

        test_reset();
        test_cpu_read();
        test_host_write_cpu_read();
        test_round_robin();
        test_host_prio();
        test_req_drop();
        test_reset_mid_access();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
